program_counter_nb: RTL

Registered D-bit program counter with a small return-address stack (RAS). It sits directly downstream of the D-bit increment/decrement unit and holds the current instruction address. Each cycle it loads, increments, decrements or holds its value, or performs a call/return, and drives the address to instruction memory.

---
 rtl/program_counter_nb.sv | 130 +++++++++++++
 1 files changed

// File: rtl/program_counter_nb.sv
// Registered program counter with load/inc/dec and an optional return-address stack.
// Build with PC_RAS_EN defined to include the stack; otherwise call acts as a jump and ret is ignored.
module program_counter_nb #(
   parameter int D     = 16,
   parameter int DEPTH = 4
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_load,
   input  logic [D-1:0] i_load_val,
   input  logic         i_inc,
   input  logic         i_dec,
   input  logic         i_call,
   input  logic [D-1:0] i_call_target,
   input  logic         i_ret,
   output logic [D-1:0] o_pc,
   output logic         o_ras_full,
   output logic         o_ras_empty,
   output logic         o_ras_err
);

   localparam logic [D-1:0] PC_ONE = D'(1);

   logic [D-1:0] pc_q, pc_d;

`ifdef PC_RAS_EN
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
   logic [D-1:0]  ras_q [DEPTH];
   logic          push;
   logic [AW-1:0] push_idx;
   logic [AW-1:0] top_idx;
   logic          ras_full;
   logic          ras_empty;

   assign ras_full  = (cnt_q == CNT_FULL);
   assign ras_empty = (cnt_q == '0);
   assign push_idx  = AW'(cnt_q);
   assign top_idx   = AW'(cnt_q - CNT_ONE);

   // Fixed priority: load > call > ret > inc > dec > hold.
   always_comb begin
      pc_d  = pc_q;
      cnt_d = cnt_q;
      err_d = 1'b0;
      push  = 1'b0;
      if (i_load) begin
         pc_d = i_load_val;
      end else if (i_call) begin
         pc_d = i_call_target;
         if (ras_full) begin
            err_d = 1'b1;
         end else begin
            push  = 1'b1;
            cnt_d = cnt_q + CNT_ONE;
         end
      end else if (i_ret) begin
         if (ras_empty) begin
            err_d = 1'b1;
         end else begin
            pc_d  = ras_q[top_idx];
            cnt_d = cnt_q - CNT_ONE;
         end
      end else if (i_inc) begin
         pc_d = pc_q + PC_ONE;
      end else if (i_dec) begin
         pc_d = pc_q - PC_ONE;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         pc_q  <= '0;
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   // Stack array is not reset; the count alone defines which entries are live.
   always_ff @(posedge i_clk) begin
      if (i_rst_n && push) begin
         ras_q[push_idx] <= pc_q + PC_ONE;
      end
   end

   assign o_ras_full  = ras_full;
   assign o_ras_empty = ras_empty;
   assign o_ras_err   = err_q;
`else
   logic unused_ret;
   assign unused_ret = ^{i_ret, DEPTH[0]};

   always_comb begin
      pc_d = pc_q;
      if (i_load) begin
         pc_d = i_load_val;
      end else if (i_call) begin
         pc_d = i_call_target;
      end else if (i_inc) begin
         pc_d = pc_q + PC_ONE;
      end else if (i_dec) begin
         pc_d = pc_q - PC_ONE;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         pc_q <= '0;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign o_ras_full  = 1'b0;
   assign o_ras_empty = 1'b1;
   assign o_ras_err   = 1'b0;
`endif

   assign o_pc = pc_q;

endmodule
